// File: rtl/stopwatch_core.sv
// 4-digit BCD millisecond stopwatch with start/stop/hold-to-count control
// and a multiplexed active-low 7-segment display driver.
module stopwatch_core #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        inc,
  input  logic        tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] count,
  output logic [1:0]  state
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_STOP  = 2'b00,
    S_START = 2'b01,
    S_INC   = 2'b10
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [15:0]   cnt;
  logic [3:0]    adv;
  logic          cen;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    dig;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_STOP;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_STOP;
    case (cur)
      S_STOP: begin
        priority case (1'b1)
          stop:    nxt = S_STOP;
          start:   nxt = S_START;
          inc:     nxt = S_INC;
          default: nxt = S_STOP;
        endcase
      end
      S_START: nxt = stop ? S_STOP : S_START;
      S_INC: begin
        priority case (1'b1)
          stop:    nxt = S_STOP;
          start:   nxt = S_START;
          inc:     nxt = S_INC;
          default: nxt = S_STOP;
        endcase
      end
      default: nxt = S_STOP;
    endcase
  end

  assign cen = (cur != S_STOP);

  // Ripple-carry enables: digit k steps when all lower digits are 9
  always_comb begin
    adv[0] = cen & tick;
    for (int k = 1; k < 4; k++)
      adv[k] = adv[k-1] & (cnt[4*(k-1) +: 4] == 4'd9);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 16'h0000;
    end else begin
      for (int k = 0; k < 4; k++)
        if (adv[k])
          cnt[4*k +: 4] <= (cnt[4*k +: 4] == 4'd9)
                           ? 4'd0 : cnt[4*k +: 4] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PMAX) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign dig = cnt[{idx, 2'b00} +: 4];

  always_comb begin
    seg = 7'b1111111;
    case (dig)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign an    = ~(4'b0001 << idx);
  assign dp    = (idx != 2'd3);
  assign count = cnt;
  assign state = cur;

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised self-checking bench for stopwatch_core against an
// arithmetic model of count, control state and display scan.
module tb_stopwatch_core;

  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        inc = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] count;
  logic [1:0]  state;

  int nchecks = 0;
  int nfail = 0;

  int m_state = 0;
  int m_count = 0;
  int m_scan = 0;
  int m_presc = 0;

  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  stopwatch_core #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .inc(inc), .tick(tick), .an(an), .seg(seg), .dp(dp),
    .count(count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] exp_an();
    return ~(4'b0001 << m_scan);
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    d = (m_count / (10 ** m_scan)) % 10;
    return segtab[d];
  endfunction

  // Model: advance one clock using the inputs currently applied
  task automatic model_step();
    int ns;
    if (reset) begin
      m_state = 0; m_count = 0; m_scan = 0; m_presc = 0;
      return;
    end
    if (m_state != 0 && tick) m_count = (m_count + 1) % 10000;
    case (m_state)
      0: ns = stop ? 0 : start ? 1 : inc ? 2 : 0;
      1: ns = stop ? 0 : 1;
      2: ns = stop ? 0 : start ? 1 : inc ? 2 : 0;
      default: ns = 0;
    endcase
    m_state = ns;
    if (m_presc == SD - 1) begin
      m_presc = 0;
      m_scan = (m_scan + 1) % 4;
    end else begin
      m_presc++;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0; inc = 0; tick = 0;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      tick = 1; cyc();
      tick = 0; cyc();
    end
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++;
    if (state !== 2'b00) begin
      nfail++; $display("FAIL rst_state got=%b exp=00", state);
    end
    nchecks++;
    if (count !== 16'h0000) begin
      nfail++; $display("FAIL rst_count got=%h exp=0000", count);
    end
    nchecks++;
    if (an !== 4'b1110) begin
      nfail++; $display("FAIL rst_an got=%b exp=1110", an);
    end
    nchecks++;
    if (seg !== 7'b1000000) begin
      nfail++; $display("FAIL rst_seg got=%b exp=1000000", seg);
    end
    nchecks++;
    if (dp !== 1'b1) begin
      nfail++; $display("FAIL rst_dp got=%b exp=1", dp);
    end
    pulse_ticks(10);
    nchecks++;
    if (count !== 16'h0000) begin
      nfail++; $display("FAIL stop_ticks got=%h exp=0000", count);
    end
  endtask

  task automatic test_start_stop();
    do_reset();
    start = 1; cyc(); start = 0;
    pulse_ticks(12);
    nchecks++;
    if (state !== 2'b01 || count !== 16'h0012) begin
      nfail++;
      $display("FAIL start12 got=%b/%h exp=01/0012", state, count);
    end
    stop = 1; cyc(); stop = 0;
    pulse_ticks(5);
    nchecks++;
    if (state !== 2'b00 || count !== 16'h0012) begin
      nfail++;
      $display("FAIL stop5 got=%b/%h exp=00/0012", state, count);
    end
  endtask

  task automatic test_rollover();
    do_reset();
    start = 1; cyc(); start = 0;
    tick = 1;
    repeat (999) cyc();
    nchecks++;
    if (count !== 16'h0999) begin
      nfail++; $display("FAIL pre999 got=%h exp=0999", count);
    end
    cyc();
    nchecks++;
    if (count !== 16'h1000) begin
      nfail++; $display("FAIL to1000 got=%h exp=1000", count);
    end
    repeat (8999) cyc();
    nchecks++;
    if (count !== 16'h9999) begin
      nfail++; $display("FAIL pre9999 got=%h exp=9999", count);
    end
    cyc();
    tick = 0;
    nchecks++;
    if (count !== 16'h0000) begin
      nfail++; $display("FAIL wrap got=%h exp=0000", count);
    end
  endtask

  task automatic test_inc();
    do_reset();
    inc = 1; cyc();
    nchecks++;
    if (state !== 2'b10) begin
      nfail++; $display("FAIL inc_state got=%b exp=10", state);
    end
    pulse_ticks(3);
    nchecks++;
    if (state !== 2'b10 || count !== 16'h0003) begin
      nfail++;
      $display("FAIL inc3 got=%b/%h exp=10/0003", state, count);
    end
    inc = 0; cyc();
    nchecks++;
    if (state !== 2'b00) begin
      nfail++; $display("FAIL inc_rel got=%b exp=00", state);
    end
    pulse_ticks(4);
    nchecks++;
    if (count !== 16'h0003) begin
      nfail++; $display("FAIL inc_ign got=%h exp=0003", count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    nchecks++;
    if (state !== 2'b00) begin
      nfail++; $display("FAIL ss_stop got=%b exp=00", state);
    end
    start = 1; cyc(); start = 0;
    inc = 1; cyc();
    nchecks++;
    if (state !== 2'b01) begin
      nfail++; $display("FAIL st_inc got=%b exp=01", state);
    end
    stop = 1; cyc(); stop = 0; inc = 0;
    nchecks++;
    if (state !== 2'b00) begin
      nfail++; $display("FAIL st_stopinc got=%b exp=00", state);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] sg_seq [4] = '{7'b0011001, 7'b0110000,
                               7'b0100100, 7'b1111001};
    int k;
    do_reset();
    start = 1; cyc(); start = 0;
    tick = 1;
    repeat (1234) cyc();
    tick = 0;
    stop = 1; cyc(); stop = 0;
    nchecks++;
    if (count !== 16'h1234) begin
      nfail++; $display("FAIL scan_pre got=%h exp=1234", count);
    end
    for (int i = 0; i < 16; i++) begin
      k = m_scan;
      nchecks++;
      if (an !== an_seq[k] || seg !== sg_seq[k] || dp !== (k != 3)) begin
        nfail++;
        $display("FAIL scan%0d got=%b/%b/%b exp=%b/%b/%b", i,
                 an, seg, dp, an_seq[k], sg_seq[k], k != 3);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      inc   = ($urandom_range(0, 9) < 3);
      tick  = $urandom_range(0, 1);
      cyc();
      nchecks++;
      if (state !== 2'(m_state) || count !== bcd(m_count) ||
          an !== exp_an() || seg !== exp_seg() ||
          dp !== (m_scan != 3)) begin
        nfail++;
        $display("FAIL rnd%0d got=%b/%h/%b/%b/%b exp=%0d/%h/%b/%b/%b",
                 i, state, count, an, seg, dp, m_state, bcd(m_count),
                 exp_an(), exp_seg(), m_scan != 3);
      end
    end
    reset = 0; start = 0; stop = 0; inc = 0; tick = 0;
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_rollover();
    test_inc();
    test_priority();
    test_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- 4-digit decimal stopwatch core: a 3-state control FSM, four cascaded BCD digit counters and a time-multiplexed, active-low 7-segment display driver.
- Sits between the push-button inputs, a 1 kHz tick-enable generator (external, one `clk`-wide pulse per ms) and the board's 4-digit common-anode display.
- Count is in milliseconds, 0000..9999.

Parameters:
- SCAN_DIV, 100000: `clk` cycles per display digit slot. Minimum 1; benches override to a small value.

Ports:
- clk    in   1   system clock, all state on rising edge
- reset  in   1   synchronous, active-high
- start  in   1   start button, level, synchronous to `clk`
- stop   in   1   stop button, level
- inc    in   1   increment (hold-to-count) button, level
- tick   in   1   count-enable pulse, 1 `clk` wide, nominally 1 kHz
- an     out  4   digit anodes, active low; an[0]=units ... an[3]=thousands
- seg    out  7   segments, active low; seg[0]=a ... seg[6]=g
- dp     out  1   decimal point, active low
- count  out  16  BCD count {thousands,hundreds,tens,units}
- state  out  2   FSM state: STOP=00, START=01, INC=10

Behaviour:
- Reset: state=STOP, count=16'h0000, scan index=0, scan prescaler=0. Outputs after reset: an=4'b1110, seg=7'b1000000, dp=1.
- FSM is registered; next state is decided each `clk` with priority stop > start > inc.
  - STOP: start -> START; else inc -> INC; else stay.
  - START: stop -> STOP; else stay. inc is ignored.
  - INC: stop -> STOP; start -> START; inc low -> STOP; else stay.
  - Code 11 is unreachable; if ever entered, it goes to STOP on the next `clk`.
- Counting enable: cen = (state != STOP).
  - Units digit advances on a `clk` edge where cen && tick.
  - Digit k (k>0) advances when cen && tick and all lower digits == 9.
  - Each digit counts 0..9 and returns to 0 after 9.
  - 9999 + 1 -> 0000; there is no overflow flag.
  - The new count is visible on `count` on the same edge that samples the tick (1-cycle latency from tick high).
  - tick while in STOP: no change.
  - Reset has priority over counting.
- The state used for cen is the registered state, so the first countable tick is the cycle after the state transition.
- Display scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, scan index (2 bits) increments, 3 -> 0.
  - an is one-hot low for the scan index.
  - seg is the combinational decode of the selected digit.
- Segment codes (seg[6:0], g..a, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any non-BCD value = 1111111 (blank).
- dp = 0 only while the scan index = 3, so the point appears after the thousands digit (reads as s.mmm). Otherwise dp = 1.
- Reset mid-scan or mid-count returns the block to the reset values on the next edge.

Test Plan:
- Reset -> state=00, count=0000, an=1110, seg=1000000, dp=1. Ten tick pulses in STOP -> count stays 0000.
- Pulse start, then 12 ticks -> state=01, count=0012. Pulse stop, 5 more ticks -> state=00, count=0012.
- Preload count to 0999 via ticks in START, one more tick -> 1000. Preload 9999, one more tick -> 0000.
- From STOP hold inc, 3 ticks -> state=10, count=0003. Release inc -> state=00 next cycle. Further ticks ignored.
- Simultaneous start and stop from STOP -> state stays 00. stop+inc while in START -> state=00.
- SCAN_DIV=2, count=1234 -> after every 2 clocks an steps 1110, 1101, 1011, 0111. seg shows 0011001, 0110000, 0100100, 1111001 respectively. dp=0 only during an=0111.
